// File: rtl/vtg_pattern_gen.sv
// Video timing generator with registered sync/de, pixel coordinates,
// frame counter and a frame-synchronous selectable test-pattern engine.
module vtg_pattern_gen #(
  parameter int H_BPORCH   = 148,
  parameter int H_ACTIVE   = 1920,
  parameter int H_FPORCH   = 88,
  parameter int H_SYNC     = 44,
  parameter bit H_POLAR    = 1'b1,
  parameter int V_BPORCH   = 36,
  parameter int V_ACTIVE   = 1080,
  parameter int V_FPORCH   = 4,
  parameter int V_SYNC     = 5,
  parameter bit V_POLAR    = 1'b1,
  parameter int CNT_W      = 12,
  parameter int NUM_BARS   = 8,
  parameter int CHECK_LOG2 = 5
) (
  input  logic             clk_pixel,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [23:0]      solid_rgb,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic [7:0]       frame_cnt,
  output logic             sof,
  output logic [23:0]      rgb
);

  localparam int H_TOTAL = H_BPORCH + H_ACTIVE + H_FPORCH + H_SYNC;
  localparam int V_TOTAL = V_BPORCH + V_ACTIVE + V_FPORCH + V_SYNC;
  localparam int BAR_W   = H_ACTIVE / NUM_BARS;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_S = CNT_W'(H_BPORCH);
  localparam logic [CNT_W-1:0] H_ACT_E = CNT_W'(H_BPORCH + H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYN_S =
    CNT_W'(H_BPORCH + H_ACTIVE + H_FPORCH);
  localparam logic [CNT_W-1:0] V_ACT_S = CNT_W'(V_BPORCH);
  localparam logic [CNT_W-1:0] V_ACT_E = CNT_W'(V_BPORCH + V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYN_S =
    CNT_W'(V_BPORCH + V_ACTIVE + V_FPORCH);
  localparam logic [CNT_W-1:0] BAR_W_M1 = CNT_W'(BAR_W - 1);
  localparam logic [5:0]       BAR_LAST = 6'(NUM_BARS - 1);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [CNT_W-1:0] bpix_q, bpix_d;
  logic [5:0]       bar_q, bar_d;
  logic [7:0]       frame_q, frame_d;
  logic [1:0]       mode_q, mode_d;
  logic [23:0]      solid_q, solid_d;
  logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d, sof_q, sof_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic [23:0]      rgb_q, rgb_d;

  logic             h_act, v_act, fb;
  logic [CNT_W-1:0] xc, yc;
  logic [2:0]       pal_idx;
  logic [23:0]      pal, pat;

  always_comb begin
    fb    = (h_cnt_q == '0) && (v_cnt_q == '0);
    h_act = (h_cnt_q >= H_ACT_S) && (h_cnt_q < H_ACT_E);
    v_act = (v_cnt_q >= V_ACT_S) && (v_cnt_q < V_ACT_E);
    xc    = h_cnt_q - H_ACT_S;
    yc    = v_cnt_q - V_ACT_S;

    h_cnt_d = '0;
    v_cnt_d = '0;
    frame_d = frame_q;
    if (en) begin
      h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        if (v_cnt_q == V_LAST) frame_d = frame_q + 8'd1;
      end
    end

    // pattern settings are latched only at the frame origin (tear-free)
    mode_d  = fb ? mode : mode_q;
    solid_d = fb ? solid_rgb : solid_q;

    bar_d  = '0;
    bpix_d = '0;
    if (en && h_act) begin
      if (bpix_q == BAR_W_M1 && bar_q != BAR_LAST) begin
        bar_d = bar_q + 6'd1;
      end else begin
        bar_d  = bar_q;
        bpix_d = bpix_q + 1'b1;
      end
    end

    pal_idx = 3'(bar_q & 6'h7);
    case (pal_idx)
      3'd0:    pal = 24'hFFFFFF;
      3'd1:    pal = 24'hFFFF00;
      3'd2:    pal = 24'h00FFFF;
      3'd3:    pal = 24'h00FF00;
      3'd4:    pal = 24'hFF00FF;
      3'd5:    pal = 24'hFF0000;
      3'd6:    pal = 24'h0000FF;
      default: pal = 24'h000000;
    endcase

    case (mode_d)
      2'd0:    pat = pal;
      2'd1:    pat = (xc[CHECK_LOG2] ^ yc[CHECK_LOG2]) ?
                     24'hFFFFFF : 24'h000000;
      2'd2:    pat = {xc[7:0], yc[7:0], frame_q};
      default: pat = solid_d;
    endcase

    de_d  = en && h_act && v_act;
    hs_d  = (en && h_cnt_q >= H_SYN_S) ? H_POLAR : ~H_POLAR;
    vs_d  = (en && v_cnt_q >= V_SYN_S) ? V_POLAR : ~V_POLAR;
    x_d   = de_d ? xc : '0;
    y_d   = de_d ? yc : '0;
    sof_d = de_d && (xc == '0) && (yc == '0);
    rgb_d = de_d ? pat : 24'h000000;
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      bpix_q  <= '0;
      bar_q   <= '0;
      frame_q <= '0;
      mode_q  <= '0;
      solid_q <= '0;
      hs_q    <= ~H_POLAR;
      vs_q    <= ~V_POLAR;
      de_q    <= 1'b0;
      sof_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      rgb_q   <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      bpix_q  <= bpix_d;
      bar_q   <= bar_d;
      frame_q <= frame_d;
      mode_q  <= mode_d;
      solid_q <= solid_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      sof_q   <= sof_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rgb_q   <= rgb_d;
    end
  end

  assign hs        = hs_q;
  assign vs        = vs_q;
  assign de        = de_q;
  assign x         = x_q;
  assign y         = y_q;
  assign frame_cnt = frame_q;
  assign sof       = sof_q;
  assign rgb       = rgb_q;

endmodule
